// File: rtl/rom_arb_pkg.sv
// ---------------------------------------------------------------------------
// rom_arb_pkg
//   Shared definitions for the ROM arbiter: FSM state encoding, requester
//   port indices and the default data word returned on an aborted access.
// ---------------------------------------------------------------------------
package rom_arb_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    IDLE  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rom_arb_grant.sv
// ---------------------------------------------------------------------------
// rom_arb_grant
//   Combinational grant selection between the fetch and data-load ports.
//   Build option: ROM_ARB_RR_EN
//     defined   : on conflict the port that was not granted last wins.
//     undefined : on conflict the data-load port always wins.
// Ports
//   pend_i     [1:0]  outstanding request per port
//   rr_last_i         port granted most recently
//   gnt_o             selected port index
//   vld_o             at least one request outstanding
// ---------------------------------------------------------------------------
module rom_arb_grant
  import rom_arb_pkg::*;
(
  input  logic [1:0] pend_i,
  input  logic       rr_last_i,
  output logic       gnt_o,
  output logic       vld_o
);

  assign vld_o = |pend_i;

`ifdef ROM_ARB_RR_EN
  always_comb begin
    gnt_o = PORT_FETCH;
    if (&pend_i) begin
      gnt_o = ~rr_last_i;
    end else if (pend_i[PORT_DATA]) begin
      gnt_o = PORT_DATA;
    end
  end
`else
  // Fixed priority does not look at history.
  logic unused_rr_last;
  assign unused_rr_last = rr_last_i;

  always_comb begin
    gnt_o = PORT_FETCH;
    if (pend_i[PORT_DATA]) begin
      gnt_o = PORT_DATA;
    end
  end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// ---------------------------------------------------------------------------
// rom_arbiter
//   Shares one toggle-handshake ROM port between the fetch requester (port 0)
//   and the data-load requester (port 1). One ROM access is in flight at a
//   time; an access that gets no completion within TIMEOUT cycles is
//   answered with ERR_DATA and the late completion is drained afterwards.
//   Build option: ROM_ARB_RR_EN selects round-robin instead of data-port
//   priority on simultaneous requests (see rom_arb_grant).
// Ports
//   clk, reset                  clock (rising edge), async active-low reset
//   p0_trig/p0_addr             fetch request toggle and address
//   p0_data/p0_ready            fetch read data, 1 = idle/data valid
//   p1_trig/p1_addr             data-load request toggle and address
//   p1_data/p1_ready            data-load read data, 1 = idle/data valid
//   rom_trig/rom_addr           ROM request toggle and address
//   rom_done/rom_data           ROM completion toggle and read data
//   timeout_err                 one-cycle pulse on an aborted access
// ---------------------------------------------------------------------------
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 64,
  parameter logic [DW-1:0] ERR_DATA = DW'(ERR_DATA_DEFAULT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_trig,
  input  logic [AW-1:0] p0_addr,
  output logic [DW-1:0] p0_data,
  output logic          p0_ready,
  input  logic          p1_trig,
  input  logic [AW-1:0] p1_addr,
  output logic [DW-1:0] p1_data,
  output logic          p1_ready,
  output logic          rom_trig,
  output logic [AW-1:0] rom_addr,
  input  logic          rom_done,
  input  logic [DW-1:0] rom_data,
  output logic          timeout_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic [1:0]      seen_trig_q, seen_trig_d;
  logic            seen_done_q, seen_done_d;
  logic            gnt_q, gnt_d;
  logic            rr_last_q, rr_last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rom_trig_q, rom_trig_d;
  logic [AW-1:0]   rom_addr_q, rom_addr_d;
  logic [DW-1:0]   p_data_q [2];
  logic [DW-1:0]   p_data_d [2];
  logic [1:0]      p_ready_q, p_ready_d;
  logic            timeout_err_q, timeout_err_d;

  logic [1:0]      trig;
  logic [1:0]      pend;
  logic            gnt;
  logic            gnt_vld;
  logic            done_evt;
  logic            timeout_hit;

  assign trig        = {p1_trig, p0_trig};
  assign pend        = trig ^ seen_trig_q;
  assign done_evt    = rom_done ^ seen_done_q;
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  rom_arb_grant u_grant (
    .pend_i    (pend),
    .rr_last_i (rr_last_q),
    .gnt_o     (gnt),
    .vld_o     (gnt_vld)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SYNC:  state_d = IDLE;
      IDLE:  if (gnt_vld) state_d = WAIT;
      WAIT: begin
        if (done_evt)         state_d = IDLE;
        else if (timeout_hit) state_d = DRAIN;
      end
      DRAIN: if (done_evt) state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    seen_trig_d   = seen_trig_q;
    seen_done_d   = seen_done_q;
    gnt_d         = gnt_q;
    rr_last_d     = rr_last_q;
    cnt_d         = cnt_q;
    rom_trig_d    = rom_trig_q;
    rom_addr_d    = rom_addr_q;
    p_data_d      = p_data_q;
    p_ready_d     = p_ready_q;
    timeout_err_d = 1'b0;

    unique case (state_q)
      SYNC: begin
        // Adopt whatever level the ROM left on rom_done.
        seen_done_d = rom_done;
      end
      IDLE: begin
        // Any done toggle seen here is spurious; just resync.
        seen_done_d = rom_done;
        if (gnt_vld) begin
          rom_addr_d        = gnt ? p1_addr : p0_addr;
          rom_trig_d        = ~rom_trig_q;
          seen_trig_d[gnt]  = trig[gnt];
          cnt_d             = '0;
          gnt_d             = gnt;
          rr_last_d         = gnt;
        end
      end
      WAIT: begin
        if (done_evt) begin
          p_data_d[gnt_q]  = rom_data;
          p_ready_d[gnt_q] = 1'b1;
          seen_done_d      = rom_done;
        end else if (timeout_hit) begin
          p_data_d[gnt_q]  = ERR_DATA;
          p_ready_d[gnt_q] = 1'b1;
          timeout_err_d    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        // Swallow the late completion of the aborted access.
        if (done_evt) begin
          seen_done_d = rom_done;
        end
      end
      default: ;
    endcase

    // A newly seen toggle drops ready; this overrides a completion on the
    // same port in the same cycle.
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) begin
        p_ready_d[i] = 1'b0;
      end
    end
  end

  // Datapath / output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seen_trig_q   <= '0;
      seen_done_q   <= 1'b0;
      gnt_q         <= PORT_FETCH;
      rr_last_q     <= PORT_DATA;
      cnt_q         <= '0;
      rom_trig_q    <= 1'b0;
      rom_addr_q    <= '0;
      p_data_q[0]   <= '0;
      p_data_q[1]   <= '0;
      p_ready_q     <= 2'b11;
      timeout_err_q <= 1'b0;
    end else begin
      seen_trig_q   <= seen_trig_d;
      seen_done_q   <= seen_done_d;
      gnt_q         <= gnt_d;
      rr_last_q     <= rr_last_d;
      cnt_q         <= cnt_d;
      rom_trig_q    <= rom_trig_d;
      rom_addr_q    <= rom_addr_d;
      p_data_q      <= p_data_d;
      p_ready_q     <= p_ready_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign p0_data     = p_data_q[0];
  assign p1_data     = p_data_q[1];
  assign p0_ready    = p_ready_q[0];
  assign p1_ready    = p_ready_q[1];
  assign rom_trig    = rom_trig_q;
  assign rom_addr    = rom_addr_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_trig, p1_trig;
  logic [31:0] p0_addr, p1_addr;
  logic [31:0] p0_data, p1_data;
  logic        p0_ready, p1_ready;
  logic        rom_trig;
  logic [31:0] rom_addr;
  logic        rom_done;
  logic [31:0] rom_data;
  logic        timeout_err;

  rom_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .p0_trig     (p0_trig),
    .p0_addr     (p0_addr),
    .p0_data     (p0_data),
    .p0_ready    (p0_ready),
    .p1_trig     (p1_trig),
    .p1_addr     (p1_addr),
    .p1_data     (p1_data),
    .p1_ready    (p1_ready),
    .rom_trig    (rom_trig),
    .rom_addr    (rom_addr),
    .rom_done    (rom_done),
    .rom_data    (rom_data),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   trig_toggles = 0;
  logic tb_last = 1'b1;
  logic rom_silent = 1'b0;
  int   rom_delay = 4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic port, input logic [31:0] data, input logic err);
    exp_t e;
    e.port = port;
    e.data = data;
    e.err  = err;
    exp_q.push_back(e);
    tb_last = port;
  endtask

  // Call right after a negedge.
  task automatic drive(input logic port, input logic [31:0] addr);
    if (port) begin
      p1_addr = addr;
      p1_trig = ~p1_trig;
    end else begin
      p0_addr = addr;
      p0_trig = ~p0_trig;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && p0_ready && p1_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s: no completion within 200 cycles, %0d outstanding", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ROM responder: sees a request one negedge after rom_trig toggles and
  // answers rom_delay negedges later unless silenced.
  initial begin : rom_model
    logic        seen;
    logic        busy;
    int          cnt;
    logic [31:0] a;
    seen = 1'b0;
    busy = 1'b0;
    cnt  = 0;
    a    = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        seen = rom_trig;
        busy = 1'b0;
      end else if (rom_trig != seen) begin
        seen = rom_trig;
        a    = rom_addr;
        cnt  = rom_delay;
        busy = 1'b1;
      end else if (busy && !rom_silent) begin
        cnt--;
        if (cnt <= 0) begin
          rom_data = (a == 32'h10) ? 32'hE3A0_0001 : {a[15:0], ~a[15:0]};
          rom_done = ~rom_done;
          busy     = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every rising ready pops one expected response.
  initial begin : monitor
    logic [1:0] prev;
    logic [1:0] rdy;
    logic       prev_trig;
    exp_t       e;
    prev      = 2'b11;
    prev_trig = 1'b0;
    forever begin
      @(negedge clk);
      rdy = {p1_ready, p0_ready};
      if (reset) begin
        if (rom_trig != prev_trig) trig_toggles++;
        for (int p = 0; p < 2; p++) begin
          if (!prev[p] && rdy[p]) begin
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_completion: port %0d rose with nothing expected", p);
            end else begin
              e = exp_q.pop_front();
              chk("ret_port", 32'(p), 32'(e.port));
              chk("ret_data", (p == 1) ? p1_data : p0_data, e.data);
              chk("ret_err", 32'(timeout_err), 32'(e.err));
            end
          end
        end
      end
      prev      = rdy;
      prev_trig = rom_trig;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic        old_done;
    logic        winner;
    int          n;
    reset    = 1'b0;
    p0_trig  = 1'b0;
    p1_trig  = 1'b0;
    p0_addr  = '0;
    p1_addr  = '0;
    rom_done = 1'b1;
    rom_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 1: reset state with rom_done held high, single fetch request
    chk("rst_p0_ready", 32'(p0_ready), 32'd1);
    chk("rst_p1_ready", 32'(p1_ready), 32'd1);
    chk("rst_p0_data", p0_data, 32'h0);
    chk("rst_rom_trig", 32'(rom_trig), 32'd0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    drive(1'b0, 32'h10);
    push(1'b0, 32'hE3A0_0001, 1'b0);
    @(negedge clk);
    chk("t1_p0_ready_low", 32'(p0_ready), 32'd0);
    chk("t1_rom_trig", 32'(rom_trig), 32'd1);
    chk("t1_rom_addr", rom_addr, 32'h10);

    // 2: done toggle -> ready exactly one edge later
    old_done = rom_done;
    n = 0;
    while (rom_done == old_done && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("t2_done_seen", 32'(rom_done != old_done), 32'd1);
    chk("t2_ready_before", 32'(p0_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("t2_ready_after", 32'(p0_ready), 32'd1);
    chk("t2_p0_data", p0_data, 32'hE3A0_0001);
    wait_idle("t2");
    chk("t1_single_toggle", 32'(trig_toggles), 32'd1);

    // 3: four simultaneous conflicts
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
`ifdef ROM_ARB_RR_EN
      winner = ~tb_last;
`else
      winner = 1'b1;
`endif
      drive(1'b0, 32'h20);
      drive(1'b1, 32'h80);
      if (winner) begin
        push(1'b1, 32'h0080_FF7F, 1'b0);
        push(1'b0, 32'h0020_FFDF, 1'b0);
      end else begin
        push(1'b0, 32'h0020_FFDF, 1'b0);
        push(1'b1, 32'h0080_FF7F, 1'b0);
      end
      @(negedge clk);
      chk("t3_first_addr", rom_addr, winner ? 32'h80 : 32'h20);
      wait_idle("t3");
    end

    // 4: silent ROM -> timeout, late done drained, next request served
    rom_silent = 1'b1;
    @(negedge clk);
    drive(1'b1, 32'h80);
    push(1'b1, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    n = 0;
    while (!timeout_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t4_timeout_cycles", 32'(n), 32'd8);
    @(negedge clk);
    chk("t4_pulse_width", 32'(timeout_err), 32'd0);
    drive(1'b0, 32'h30);
    push(1'b0, 32'h0030_FFCF, 1'b0);
    repeat (2) @(negedge clk);
    chk("t4_drain_blocks", 32'(trig_toggles), 32'd10);
    chk("t4_drain_pending", 32'(p0_ready), 32'd0);
    rom_silent = 1'b0;
    wait_idle("t4");
    chk("t4_after_drain", 32'(trig_toggles), 32'd11);

    // 6: spurious done in IDLE
    @(negedge clk);
    rom_done = ~rom_done;
    repeat (3) @(negedge clk);
    chk("t6_p0_ready", 32'(p0_ready), 32'd1);
    chk("t6_p1_ready", 32'(p1_ready), 32'd1);
    chk("t6_p0_data", p0_data, 32'h0030_FFCF);
    chk("t6_p1_data", p1_data, 32'hDEAD_BEEF);
    chk("t6_no_access", 32'(trig_toggles), 32'd11);
    drive(1'b0, 32'h50);
    push(1'b0, 32'h0050_FFAF, 1'b0);
    repeat (3) @(negedge clk);
    chk("t6_waits_own_done", 32'(p0_ready), 32'd0);
    wait_idle("t6");

    // 5: reset dropped mid-WAIT
    rom_silent = 1'b1;
    @(negedge clk);
    drive(1'b0, 32'h40);
    repeat (3) @(negedge clk);
    chk("t5_pre_rom_trig", 32'(rom_trig), 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk("t5_p0_ready", 32'(p0_ready), 32'd1);
    chk("t5_p1_ready", 32'(p1_ready), 32'd1);
    chk("t5_rom_trig", 32'(rom_trig), 32'd0);
    chk("t5_p0_data", p0_data, 32'h0);
    chk("t5_rom_addr", rom_addr, 32'h0);
    p0_trig    = 1'b0;
    p1_trig    = 1'b0;
    rom_silent = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    drive(1'b1, 32'h44);
    push(1'b1, 32'h0044_FFBB, 1'b0);
    wait_idle("t5");
    chk("t5_post_p1_data", p1_data, 32'h0044_FFBB);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
